c2h_packet_scheduler: RTL

Packet-level gate between the data-producer AXI4-Stream FIFO output and the XDMA C2H stream input, in the `user_clk` domain. It releases data only as whole packets of 2^PKT_WIDTH words, and only once the FIFO reports a full packet available. It forces `tlast` on the packet boundary, inserts a programmable idle gap between DMA packets as required by the Linux XDMA driver, and flags framing errors from upstream.

---
 rtl/c2h_packet_scheduler.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/c2h_packet_scheduler.sv
// c2h_packet_scheduler
// Packet-level gate between the producer AXI4-Stream FIFO and the XDMA C2H stream.
// Releases data only as whole packets of 2**PKT_WIDTH words once the FIFO reports a full
// packet, generates tlast on the packet boundary, inserts a programmable idle gap between
// packets and flags upstream framing errors.
//
// Optional feature macro: C2H_SCHED_STATS_EN
//   defined   -> pkt_cnt / underrun_cnt counters implemented
//   undefined -> both outputs tied to 0, no counter flops
//
// Ports:
//   user_clk, user_rst      clock, synchronous active-high reset
//   dma_ena                 enable, sampled in IDLE only (packets are atomic)
//   pkt_avail               FIFO holds at least one full packet
//   gap_len                 inter-packet gap, GAP lasts gap_len+1 cycles
//   s_axis_*                upstream stream from FIFO (tlast checked, not forwarded)
//   m_axis_*                downstream stream to XDMA C2H (tlast generated, tkeep all ones)
//   busy                    state != IDLE
//   framing_err             sticky: upstream tlast disagreed with generated tlast on a beat
//   pkt_cnt                 packets completed, wraps
//   underrun_cnt            XFER cycles with s_axis_tvalid low, saturating
module c2h_packet_scheduler #(
   parameter int DATA_WIDTH = 64,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8,
   parameter int PKT_WIDTH  = 11,
   parameter int WAIT_WIDTH = 4
) (
   input  logic                  user_clk,
   input  logic                  user_rst,
   input  logic                  dma_ena,
   input  logic                  pkt_avail,
   input  logic [WAIT_WIDTH-1:0] gap_len,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  busy,
   output logic                  framing_err,
   output logic [31:0]           pkt_cnt,
   output logic [15:0]           underrun_cnt
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StXfer = 2'd1,
      StGap  = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [PKT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
   logic [WAIT_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
   logic                  beat;
   logic                  last_beat;

   // Data is a pure pass-through; only the handshake is gated.
   assign m_axis_tdata = s_axis_tdata;
   assign m_axis_tkeep = '1;
   assign busy         = (state_q != StIdle);
   assign beat         = m_axis_tvalid && m_axis_tready;
   assign last_beat    = beat && m_axis_tlast;

   always_comb begin
      state_d       = state_q;
      beat_cnt_d    = beat_cnt_q;
      gap_cnt_d     = gap_cnt_q;
      m_axis_tvalid = 1'b0;
      s_axis_tready = 1'b0;
      m_axis_tlast  = 1'b0;
      case (state_q)
         StIdle: begin
            if (dma_ena && pkt_avail) begin
               state_d    = StXfer;
               beat_cnt_d = '0;
            end
         end
         StXfer: begin
            m_axis_tvalid = s_axis_tvalid;
            s_axis_tready = m_axis_tready;
            m_axis_tlast  = &beat_cnt_q;
            if (s_axis_tvalid && m_axis_tready) begin
               beat_cnt_d = beat_cnt_q + 1'b1;
               if (&beat_cnt_q) begin
                  state_d   = StGap;
                  gap_cnt_d = gap_len;
               end
            end
         end
         StGap: begin
            gap_cnt_d = gap_cnt_q - 1'b1;
            if (gap_cnt_q == '0) begin
               state_d = StIdle;
            end
         end
         // Unused encoding recovers to IDLE.
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         state_q     <= StIdle;
         beat_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         framing_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         // Generated tlast wins; a disagreement is only recorded.
         if (beat && (s_axis_tlast != m_axis_tlast)) begin
            framing_err <= 1'b1;
         end
      end
   end

`ifdef C2H_SCHED_STATS_EN
   logic [31:0] pkt_cnt_q;
   logic [15:0] underrun_cnt_q;

   always_ff @(posedge user_clk) begin
      if (user_rst) begin
         pkt_cnt_q      <= '0;
         underrun_cnt_q <= '0;
      end else begin
         if (last_beat) begin
            pkt_cnt_q <= pkt_cnt_q + 32'd1;
         end
         if ((state_q == StXfer) && !s_axis_tvalid && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
         end
      end
   end

   assign pkt_cnt      = pkt_cnt_q;
   assign underrun_cnt = underrun_cnt_q;
`else
   logic unused_last_beat;
   assign unused_last_beat = last_beat;
   assign pkt_cnt          = '0;
   assign underrun_cnt     = '0;
`endif

endmodule
